mult_div_unit: RTL and testbench

//   Multi-cycle integer multiply/divide unit for the pipeline execute stage.

---
 rtl/mult_div_unit.sv | 165 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multi-cycle integer multiply/divide unit for the execute stage.
//   Retires one result bit per clock. Multiply is shift-add into a 2*WIDTH
//   accumulator; divide is restoring shift-subtract. Results land in HI/LO.
//   busy lets the hazard unit stall mfhi/mflo until the result is in place.
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start_mult   begin src_a*src_b (sampled only while idle; wins over start_div)
//   start_div    begin src_a/src_b (sampled only while idle)
//   mult_sign    1 = signed two's-complement operands, 0 = unsigned
//   src_a/src_b  multiplicand/multiplier, dividend/divisor
//   write_hi/lo  mthi/mtlo, load wdata into hi/lo (ignored while busy)
//   wdata        data for write_hi/write_lo
//   busy         operation in progress
//   done         one-cycle pulse, hi/lo just took a result
//   div_by_zero  last divide had a zero divisor (sticky until the next divide)
//   hi/lo        product upper/lower half, or remainder/quotient
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP, S_DZ} state_t;

  state_t             r_state;
  logic               r_is_div;
  logic               r_neg_q;     // product / quotient sign
  logic               r_neg_r;     // remainder sign (dividend sign)
  logic [WIDTH-1:0]   r_opb;       // multiplicand magnitude or divisor magnitude
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: low half shifts dividend bits out and quotient bits in.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;       // partial remainder, always < divisor
  logic [CW-1:0]      r_cnt;

  // Operand magnitudes; MIN maps to itself, which is the correct unsigned magnitude.
  logic             w_neg_a, w_neg_b;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  assign w_neg_a = mult_sign & src_a[WIDTH-1];
  assign w_neg_b = mult_sign & src_b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -src_a : src_a;
  assign w_mag_b = w_neg_b ? -src_b : src_b;

  // Multiply step: conditionally add multiplicand to upper half, carry kept
  // in bit WIDTH so the right shift brings it back in.
  logic [WIDTH:0] w_sum;
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opb : '0)};

  // Divide step: the shifted partial remainder needs WIDTH+1 bits; the sign
  // of the trial difference decides the quotient bit.
  logic [WIDTH:0] w_shift, w_diff;
  logic           w_ge;
  assign w_shift = {r_rem, r_acc[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_opb};
  assign w_ge    = ~w_diff[WIDTH];

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rmd;
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rmd  = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_is_div    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_opb       <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      // mthi/mtlo; busy is low only in IDLE, so this never collides with
      // the result writes below.
      if (!busy) begin
        if (write_hi) hi <= wdata;
        if (write_lo) lo <= wdata;
      end
      case (r_state)
        S_IDLE: begin
          if (start_mult || start_div) begin
            busy     <= 1'b1;
            r_cnt    <= '0;
            r_is_div <= ~start_mult;
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_rem    <= '0;
            if (start_mult) begin
              r_opb   <= w_mag_a;
              r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
              r_state <= S_RUN;
            end else begin
              div_by_zero <= 1'b0;
              if (src_b == '0) begin
                // Raw dividend is parked for the hi writeback.
                r_acc   <= {{WIDTH{1'b0}}, src_a};
                r_state <= S_DZ;
              end else begin
                r_opb   <= w_mag_b;
                r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                r_state <= S_RUN;
              end
            end
          end
        end
        S_RUN: begin
          if (r_is_div) begin
            r_rem              <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIXUP;
        end
        S_FIXUP: begin
          if (r_is_div) begin
            lo <= w_quo;
            hi <= w_rmd;
          end else begin
            {hi, lo} <= w_prod;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        S_DZ: begin
          hi          <= r_acc[WIDTH-1:0];
          lo          <= '1;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (WIDTH=32): reset, signed/unsigned
// multiply and divide, divide by zero, mthi/mtlo, back-to-back, busy-time
// interference and mid-operation reset.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_mult = 1'b0, start_div = 1'b0, mult_sign = 1'b0;
  logic [W-1:0] src_a = '0, src_b = '0, wdata = '0;
  logic         write_hi = 1'b0, write_lo = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_chk = 0;
  int n_fail = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .start_mult(start_mult), .start_div(start_div), .mult_sign(mult_sign),
    .src_a(src_a), .src_b(src_b),
    .write_hi(write_hi), .write_lo(write_lo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op and wait for done (bounded). lat = edges from start to done;
  // bok = busy high and done low on every cycle before done, busy low at done.
  task automatic run_op(input logic m, input logic d, input logic s,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic bok);
    start_mult = m; start_div = d; mult_sign = s; src_a = a; src_b = b;
    tick();
    start_mult = 1'b0; start_div = 1'b0;
    lat = 0;
    bok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) bok = 1'b0;
      tick();
      lat++;
    end
    if (busy) bok = 1'b0;
  endtask

  initial begin
    int   lat;
    logic bok;

    // Reset state
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz",   div_by_zero, 0);
    check("rst_hi",   hi, 0);
    check("rst_lo",   lo, 0);
    tick();
    reset = 1'b1;
    tick();

    // Unsigned 7*6
    run_op(1, 0, 0, 32'd7, 32'd6, lat, bok);
    check("m76_lat",  lat, 33);
    check("m76_busy", bok, 1);
    check("m76_hi",   hi, 0);
    check("m76_lo",   lo, 32'h2A);
    tick();
    check("m76_done_pulse", done, 0);
    check("m76_hold", lo, 32'h2A);

    run_op(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bok);
    check("mff_hi", hi, 32'hFFFFFFFE);
    check("mff_lo", lo, 32'h00000001);

    run_op(1, 0, 1, -32'sd3, 32'd5, lat, bok);
    check("ms35_hi", hi, 32'hFFFFFFFF);
    check("ms35_lo", lo, 32'hFFFFFFF1);

    run_op(1, 0, 1, 32'h80000000, 32'h80000000, lat, bok);
    check("mmin_hi", hi, 32'h40000000);
    check("mmin_lo", lo, 0);

    // Divides
    run_op(0, 1, 1, -32'sd7, 32'd2, lat, bok);
    check("ds72_lat", lat, 33);
    check("ds72_lo",  lo, 32'hFFFFFFFD);
    check("ds72_hi",  hi, 32'hFFFFFFFF);

    run_op(0, 1, 0, 32'd100, 32'd7, lat, bok);
    check("d1007_lo", lo, 14);
    check("d1007_hi", hi, 2);
    check("d1007_dz", div_by_zero, 0);
    check("d1007_busy", bok, 1);

    run_op(0, 1, 0, 32'd5, 32'd0, lat, bok);
    check("dz_lat",  lat, 1);
    check("dz_hi",   hi, 5);
    check("dz_lo",   lo, 32'hFFFFFFFF);
    check("dz_flag", div_by_zero, 1);
    tick();
    check("dz_sticky", div_by_zero, 1);
    check("dz_done_pulse", done, 0);

    run_op(0, 1, 0, 32'd8, 32'd2, lat, bok);
    check("d82_lo", lo, 4);
    check("d82_hi", hi, 0);
    check("d82_dz", div_by_zero, 0);

    run_op(0, 1, 1, 32'h80000000, 32'hFFFFFFFF, lat, bok);
    check("dmin_lo", lo, 32'h80000000);
    check("dmin_hi", hi, 0);
    check("dmin_dz", div_by_zero, 0);

    // mthi/mtlo
    write_hi = 1'b1; write_lo = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    write_lo = 1'b0; wdata = 32'h12345678;
    tick();
    write_hi = 1'b0;
    check("mt_hi", hi, 32'h12345678);
    check("mt_lo", lo, 32'hDEADBEEF);

    // Back-to-back: second start issued in the done cycle of the first
    run_op(1, 0, 0, 32'd2, 32'd3, lat, bok);
    check("b2b1_lo", lo, 6);
    run_op(1, 0, 0, 32'd4, 32'd5, lat, bok);
    check("b2b2_lat", lat, 33);
    check("b2b2_lo",  lo, 20);

    // start_div and write_hi pulsed while a multiply is running
    start_mult = 1'b1; mult_sign = 1'b0; src_a = 32'd1000; src_b = 32'd1000;
    tick();
    start_mult = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 9) begin
        start_div = 1'b1; write_hi = 1'b1; wdata = 32'h0000FFFF;
        src_a = 32'd1; src_b = 32'd0;
      end
      tick();
      lat++;
      start_div = 1'b0; write_hi = 1'b0;
    end
    check("intf_lat", lat, 33);
    check("intf_hi",  hi, 0);
    check("intf_lo",  lo, 32'h000F4240);
    check("intf_dz",  div_by_zero, 0);

    // Mid-operation reset (flag set first so its clear is visible)
    run_op(0, 1, 0, 32'd7, 32'd0, lat, bok);
    check("pre_rst_dz", div_by_zero, 1);
    start_mult = 1'b1; src_a = 32'h0000FFFF; src_b = 32'h0000FFFF;
    tick();
    start_mult = 1'b0;
    repeat (20) tick();
    #2 reset = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_dz",   div_by_zero, 0);
    check("mrst_hi",   hi, 0);
    check("mrst_lo",   lo, 0);
    #1 reset = 1'b1;
    tick();

    run_op(1, 0, 0, 32'd3, 32'd3, lat, bok);
    check("post_lat", lat, 33);
    check("post_lo",  lo, 9);
    check("post_hi",  hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
